// File: rtl/brlite_svc_queue.sv
// BrLite service receive queue: router req/ack in, FIFO, NI rx/ack out.
// Ports: clk_i, rst_ni, rtr_req_i/rtr_ack_o/rtr_data_i (router side),
//   svc_rx_o/svc_ack_i/svc_data_o (NI side), full_o, discard_cnt_o.
package brlite_pkg;

    typedef struct packed {
        logic [7:0]  ksvc;
        logic [15:0] seq_source;
        logic [15:0] producer;
        logic [31:0] payload;
    } brlite_svc_t;

endpackage

module brlite_svc_queue
    import brlite_pkg::*;
#(
    parameter int          BUFFER_SIZE  = 8,
    parameter logic [15:0] ADDRESS      = 16'b0,
    parameter int          DISCARD_SELF = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rtr_req_i,
    output logic        rtr_ack_o,
    input  brlite_svc_t rtr_data_i,
    output logic        svc_rx_o,
    input  logic        svc_ack_i,
    output brlite_svc_t svc_data_o,
    output logic        full_o,
    output logic [15:0] discard_cnt_o
);

    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    state_t state_q, state_d;

    brlite_svc_t mem [BUFFER_SIZE];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   disc_q;

    logic is_self;
    logic wr_en;
    logic disc_en;
    logic pop;

    assign is_self = (DISCARD_SELF != 0)
                   && (rtr_data_i.seq_source == ADDRESS);

    assign full_o        = (count_q == CW'(BUFFER_SIZE));
    assign svc_rx_o      = (count_q != '0);
    assign svc_data_o    = mem[rd_ptr_q];
    assign rtr_ack_o     = (state_q == S_ACK);
    assign discard_cnt_o = disc_q;
    assign pop           = svc_ack_i && svc_rx_o;

    // full_o is the registered count, so a pop in the same cycle
    // does not open a slot for the incoming message until next cycle.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        disc_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rtr_req_i) begin
                    if (is_self) begin
                        disc_en = 1'b1;
                        state_d = S_ACK;
                    end else if (!full_o) begin
                        wr_en   = 1'b1;
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= rtr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            disc_q <= '0;
        end else if (disc_en && (disc_q != 16'hFFFF)) begin
            disc_q <= disc_q + 16'd1;
        end
    end

endmodule

// File: doc/brlite_svc_queue.md
# brlite_svc_queue

Receive-side buffer for BrLite service messages between the BrLite router local output port and the DMNI NI. Accepts service messages from the router with a req/ack handshake, optionally discards self-originated broadcasts, and stores them in a FIFO. Presents the head entry to the NI as `br_svc_rx`/`br_svc_data`, and pops one entry per NI `br_svc_ack` pulse. When the FIFO is full, the block applies backpressure to the router by withholding ack; messages are never dropped.

## Interface
Parameters:
- `BUFFER_SIZE`, default 8: FIFO depth in entries; power of two, minimum 2.
- `ADDRESS`, default 16'b0: PE address, compared against `seq_source`.
- `DISCARD_SELF`, default 1: when 1, messages with `seq_source == ADDRESS` are acked and not stored.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `rtr_req_i`, in, 1: router has a message on `rtr_data_i`. Held high until ack is seen.
- `rtr_ack_o`, out, 1: one-cycle accept pulse to the router.
- `rtr_data_i`, in, brlite_svc_t (72 bits: ksvc[7:0], seq_source[15:0], producer[15:0], payload[31:0]): incoming message.
- `svc_rx_o`, out, 1: FIFO not empty. Connects to NI `br_svc_rx_i`.
- `svc_ack_i`, in, 1: pop pulse from NI `br_svc_ack_o`.
- `svc_data_o`, out, brlite_svc_t: head entry. Connects to NI `br_svc_data_i`.
- `full_o`, out, 1: FIFO full, for status/debug.
- `discard_cnt_o`, out, 16: count of self-discarded messages; saturates at 16'hFFFF.

## Operation
- Storage: `BUFFER_SIZE` × 72-bit register array.
  - `wr_ptr` and `rd_ptr`: `$clog2(BUFFER_SIZE)` bits each, wrap modulo `BUFFER_SIZE`.
  - `count`: `$clog2(BUFFER_SIZE)+1` bits.
  - `svc_rx_o = (count != 0)`; `full_o = (count == BUFFER_SIZE)`.
  - `svc_data_o = mem[rd_ptr]` (combinational read). Value is don't-care when empty.
- Receive FSM, states IDLE and ACK:
  - IDLE, `rtr_req_i=1`, self-discard condition true: go to ACK, no write, increment `discard_cnt_o` (saturating).
  - IDLE, `rtr_req_i=1`, not discarded, `!full_o`: write `rtr_data_i` at `wr_ptr`, increment `wr_ptr`, go to ACK.
  - IDLE, `rtr_req_i=1`, not discarded, `full_o`: stay in IDLE, no ack. Message is held at the router.
  - ACK: `rtr_ack_o=1` (registered). `rtr_req_i` is ignored. Always return to IDLE next cycle.
  - The ACK state guarantees no double accept, because the router clears req on the edge at which it samples ack.
- Pop: on `svc_ack_i=1` with `count != 0`, increment `rd_ptr`. A pop with `count == 0` is ignored and pointers are unchanged.
- Simultaneous write and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full FIFO with a simultaneous pop: the write is still refused that cycle because `full_o` is the registered count. It is accepted the following cycle.
- Reset mid-operation: all state clears immediately and asynchronously. Buffered messages are lost. An in-flight ack is cancelled.

## Timing
- Reset values:
  - `rtr_ack_o=0`, `svc_rx_o=0`, `full_o=0`, `discard_cnt_o=0`.
  - Pointers 0, `count` 0, FSM in IDLE.
  - Memory contents are not reset.
- Accept latency:
  - Req sampled in IDLE at edge N.
  - `rtr_ack_o` high during cycle N+1 (exactly one cycle).
  - Earliest next accept at edge N+2, giving a maximum throughput of 1 message per 2 cycles.
- Visibility: a message written at edge N gives `svc_rx_o=1` and a valid `svc_data_o` during cycle N+1. There is no forwarding of `rtr_data_i` straight to the output.
- Pop: `svc_ack_i` sampled at edge N. The new head, or `svc_rx_o=0`, appears in cycle N+1.
- The NI ack is a single-cycle pulse. Every sampled high cycle pops exactly one entry.

## Test plan
- Single message: after reset, drive req with ksvc=8'h12, seq_source=16'h0101, producer=16'h0203, payload=32'hDEADBEEF (`ADDRESS=0`).
  - Expect `rtr_ack_o` high for 1 cycle.
  - Next cycle, `svc_rx_o=1` and `svc_data_o` equals the sent message.
  - Pulse `svc_ack_i`: `svc_rx_o=0` one cycle later.
- Fill and backpressure with `BUFFER_SIZE=8`: push 8 messages with payloads 0..7 and no pops.
  - `full_o=1`.
  - A 9th req stays unacked for 20 cycles.
  - One pop: 9th req is acked 2 cycles after the pop edge.
  - Drain: payloads come out in order 1..8.
- Wrap-around: 3 rounds of push-5/pop-5. Data order is preserved across the pointer wrap; `count` returns to 0.
- Simultaneous push and pop: with 3 entries, pop in the same cycle a new message is written.
  - `count` stays 3.
  - Head advances to entry 2.
  - New message appears last.
- Self discard with `ADDRESS=16'h0101`, `DISCARD_SELF=1`: send seq_source=16'h0101.
  - Ack is given, `svc_rx_o` stays 0, `discard_cnt_o=1`.
  - With `DISCARD_SELF=0`, the same message is stored.
- Reset mid-operation: with 4 entries buffered and ack high, assert `rst_ni=0` asynchronously. All outputs go to reset values immediately, and a subsequent single push/pop behaves as in the first scenario.
